// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcodes, constants, response entry type and ALU model.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_MUL = 3'd5
   } alu_op_e;

   localparam logic [15:0] ALU_ILLEGAL_RESULT = 16'hDEAD;
   localparam logic [2:0]  ALU_IDLE_OP        = 3'b111;

   typedef struct packed {
      logic [3:0]  tag;
      logic [15:0] result;
      logic        err;
   } rsp_entry_t;

   // Reference behaviour of the ALU: operands are zero-extended to 16 bits.
   function automatic logic [15:0] alu_model(input logic [2:0] op,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
      logic [15:0] ea;
      logic [15:0] eb;
      ea = {8'h00, a};
      eb = {8'h00, b};
      case (op)
         OP_ADD:  alu_model = ea + eb;
         OP_SUB:  alu_model = ea - eb;
         OP_AND:  alu_model = ea & eb;
         OP_OR:   alu_model = ea | eb;
         OP_XOR:  alu_model = ea ^ eb;
         OP_MUL:  alu_model = ea * eb;
         default: alu_model = ALU_ILLEGAL_RESULT;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issuer_if.sv
// ============================================================================
// Module   : alu_issuer_if
// Purpose  : Command, ALU and response signal bundle of the ALU issuer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_issuer_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_opcode;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic [2:0]  alu_opcode;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [15:0] alu_result;
   logic        alu_valid;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic        rsp_err;
   logic [3:0]  rsp_tag;
   logic        chk_err;

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, alu_valid, rsp_ready,
      output cmd_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_result, rsp_err,
             rsp_tag, chk_err
   );

   modport master (
      output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, alu_valid, rsp_ready,
      input  cmd_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_result, rsp_err,
             rsp_tag, chk_err
   );

endinterface

`default_nettype wire

// File: rtl/alu_rsp_fifo.sv
// ============================================================================
// Module   : alu_rsp_fifo
// Purpose  : DEPTH-entry response FIFO with combinational head and count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_rsp_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  rsp_entry_t               push_data,
   input  logic                     pop,
   output rsp_entry_t               head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   rsp_entry_t       mem_q [DEPTH];
   rsp_entry_t       mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Drained slots keep old data; present zeros rather than stale entries.
   assign empty = (count_q == '0);
   assign head  = empty ? '0 : mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/alu_issuer.sv
// ============================================================================
// Module   : alu_issuer
// Purpose  : Credit-based command issuer to a 2-cycle ALU with tagged response
//            FIFO. Define ALU_ISSUER_CHECK_EN to build the result checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_issuer
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   alu_issuer_if.slave  bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int SUM_W = CNT_W + 1;
   localparam logic [SUM_W-1:0] C_DEPTH = SUM_W'(DEPTH);

   logic [2:0]       alu_op_q, alu_op_d;
   logic [7:0]       alu_a_q, alu_a_d;
   logic [7:0]       alu_b_q, alu_b_d;
   logic [3:0]       tag_q, tag_d;
   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic [3:0]       tag1_q, tag1_d;
   logic [3:0]       tag2_q, tag2_d;

   logic             cmd_ready;
   logic             issue;
   logic             push;
   logic             pop;
   logic [1:0]       inflight;
   logic [SUM_W-1:0] credit_used;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty;
   rsp_entry_t       push_data;
   rsp_entry_t       head;

   // Outstanding = queued + in the 2-stage ALU pipe, so a push never overflows.
   assign inflight    = {1'b0, s1_q} + {1'b0, s2_q};
   assign credit_used = SUM_W'(fifo_count) + SUM_W'(inflight);
   assign cmd_ready   = !rst && (credit_used < C_DEPTH);
   assign issue       = bus.cmd_valid && cmd_ready;

   assign push      = s2_q;
   assign pop       = !fifo_empty && bus.rsp_ready;
   assign push_data = '{tag: tag2_q, result: bus.alu_result, err: ~bus.alu_valid};

   always_comb begin
      alu_op_d = ALU_IDLE_OP;
      alu_a_d  = '0;
      alu_b_d  = '0;
      tag_d    = tag_q;
      tag1_d   = tag1_q;
      tag2_d   = tag1_q;
      s1_d     = issue;
      s2_d     = s1_q;
      if (issue) begin
         alu_op_d = bus.cmd_opcode;
         alu_a_d  = bus.cmd_a;
         alu_b_d  = bus.cmd_b;
         tag1_d   = tag_q;
         tag_d    = tag_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_op_q <= ALU_IDLE_OP;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         tag_q    <= '0;
         tag1_q   <= '0;
         tag2_q   <= '0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
      end else begin
         alu_op_q <= alu_op_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         tag_q    <= tag_d;
         tag1_q   <= tag1_d;
         tag2_q   <= tag2_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
      end
   end

`ifdef ALU_ISSUER_CHECK_EN
   logic [15:0] model1_q, model1_d;
   logic [15:0] model2_q, model2_d;
   logic        chk_err_q, chk_err_d;

   // Model result rides the same two stages as the issue flag.
   always_comb begin
      model1_d  = issue ? alu_model(bus.cmd_opcode, bus.cmd_a, bus.cmd_b) : '0;
      model2_d  = model1_q;
      chk_err_d = chk_err_q | (push && (bus.alu_result != model2_q));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         model1_q  <= '0;
         model2_q  <= '0;
         chk_err_q <= 1'b0;
      end else begin
         model1_q  <= model1_d;
         model2_q  <= model2_d;
         chk_err_q <= chk_err_d;
      end
   end

   assign bus.chk_err = chk_err_q;
`else
   assign bus.chk_err = 1'b0;
`endif

   alu_rsp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign bus.cmd_ready  = cmd_ready;
   assign bus.alu_opcode = alu_op_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.rsp_valid  = !fifo_empty;
   assign bus.rsp_result = head.result;
   assign bus.rsp_err    = head.err;
   assign bus.rsp_tag    = head.tag;

endmodule

`default_nettype wire
